// File: rtl/noc_qsys_mem_copy_master.sv
// rtl/noc_qsys_mem_copy_master.sv - word copy/fill engine for a one-cycle-read-latency on-chip memory
// Define NOC_MEM_COPY_CHECKSUM_EN to add a checksum output summing every word written by the last command.
module noc_qsys_mem_copy_master #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_W-1:0]     cmd_src,
   input  logic [ADDR_W-1:0]     cmd_dst,
   input  logic [ADDR_W:0]       cmd_len,
   input  logic                  cmd_fill,
   input  logic [DATA_W-1:0]     cmd_pattern,
   input  logic                  abort,
   input  logic                  stall,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W/8-1:0]   byteenable,
   output logic                  chipselect,
   output logic                  write,
   output logic [DATA_W-1:0]     writedata,
   output logic                  clken,
   input  logic [DATA_W-1:0]     readdata,
   output logic                  busy,
   output logic                  done,
   output logic                  done_err
`ifdef NOC_MEM_COPY_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]     checksum
`endif
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0]   BE_ALL   = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_WRITE, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_q, dst_q, src_inc, dst_inc;
   logic [ADDR_W:0]   remain, remain_dec;
   logic              fill_q, cs_q, wr_q;
   logic              active, abort_hit, last_write;

   assign src_inc    = src_q + ADDR_ONE;
   assign dst_inc    = dst_q + ADDR_ONE;
   assign remain_dec = remain - LEN_ONE;
   assign active     = (state == S_READ) || (state == S_LATCH) || (state == S_WRITE);
   assign abort_hit  = abort && active;
   assign last_write = (state == S_WRITE) && (remain_dec == '0);

   // Bus strobes are registered per state but gated live so stall/abort kill the access in the same cycle.
   assign cmd_ready  = (state == S_IDLE) && !stall;
   assign clken      = !stall;
   assign chipselect = cs_q && !stall && !abort;
   assign write      = wr_q && !stall && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         remain     <= '0;
         fill_q     <= 1'b0;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         address    <= '0;
         byteenable <= '0;
         writedata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_err   <= 1'b0;
`ifdef NOC_MEM_COPY_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else if (!stall) begin
         if (state == S_WRITE && !abort) begin
            src_q  <= src_inc;
            dst_q  <= dst_inc;
            remain <= remain_dec;
`ifdef NOC_MEM_COPY_CHECKSUM_EN
            checksum <= checksum + writedata;
`endif
         end
         if (abort_hit || last_write) begin
            state      <= S_DONE;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            done       <= 1'b1;
            done_err   <= abort_hit;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cmd_valid) begin
                     src_q  <= cmd_src;
                     dst_q  <= cmd_dst;
                     remain <= cmd_len;
                     fill_q <= cmd_fill;
                     busy   <= 1'b1;
`ifdef NOC_MEM_COPY_CHECKSUM_EN
                     checksum <= '0;
`endif
                     if (cmd_len == '0) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        done_err <= 1'b0;
                     end else if (cmd_fill) begin
                        // writedata doubles as the pattern holder for the whole fill
                        state      <= S_WRITE;
                        address    <= cmd_dst;
                        writedata  <= cmd_pattern;
                        byteenable <= BE_ALL;
                        cs_q       <= 1'b1;
                        wr_q       <= 1'b1;
                     end else begin
                        state      <= S_READ;
                        address    <= cmd_src;
                        byteenable <= BE_ALL;
                        cs_q       <= 1'b1;
                        wr_q       <= 1'b0;
                     end
                  end
               end
               S_READ: begin
                  state <= S_LATCH;
                  cs_q  <= 1'b0;
               end
               S_LATCH: begin
                  state     <= S_WRITE;
                  writedata <= readdata;
                  address   <= dst_q;
                  cs_q      <= 1'b1;
                  wr_q      <= 1'b1;
               end
               S_WRITE: begin
                  if (fill_q) begin
                     address <= dst_inc;
                  end else begin
                     state   <= S_READ;
                     address <= src_inc;
                     wr_q    <= 1'b0;
                  end
               end
               S_DONE: begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b0;
                  done_err <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
